alu_cmd_issuer: RTL and testbench

- Initiator side of the 4-bit ALU operand/opcode interface.
- Accepts operation commands over a valid/ready port and buffers them in a small FIFO.
- Drives A, B and opcode to an external combinational ALU, registers the returned result, and presents it on a valid/ready response port in command order.
- Sits between the test/stimulus source (or a control unit) and the ALU.

---
 rtl/alu_cmd_issuer.sv | 185 ++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO + IDLE/EXEC/RESP sequencer that issues operands to an external combinational ALU.
// Optional expected-result model enabled by macro ALU_ISSUE_CHECK_EN (drives rsp_mismatch).
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OP_W  = 3,
    parameter int unsigned D_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [D_W-1:0]  cmd_a,
    input  logic [D_W-1:0]  cmd_b,
    input  logic [OP_W-1:0] cmd_op,
    output logic [D_W-1:0]  alu_a,
    output logic [D_W-1:0]  alu_b,
    output logic [OP_W-1:0] alu_opcode,
    input  logic [D_W-1:0]  alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [D_W-1:0]  rsp_result,
    output logic [OP_W-1:0] rsp_op,
    output logic            rsp_illegal,
    output logic            rsp_mismatch,
    output logic            busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = OP_W'(6);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [D_W-1:0]  b;
        logic [D_W-1:0]  a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    cmd_t            mem_q [DEPTH];
    cmd_t            mem_d [DEPTH];
    cmd_t            head_c;
    logic [D_W-1:0]  alu_a_q, alu_a_d;
    logic [D_W-1:0]  alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [D_W-1:0]  rsp_result_q, rsp_result_d;
    logic [OP_W-1:0] rsp_op_q, rsp_op_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic            rsp_mismatch_q, rsp_mismatch_d;
    logic            busy_q, busy_d;
    logic            full_c, empty_c, push_c, mismatch_c;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign cmd_ready = !rst && !full_c;
    assign push_c    = cmd_valid && cmd_ready;
    assign head_c    = mem_q[rd_ptr_q[AW-1:0]];

`ifdef ALU_ISSUE_CHECK_EN
    logic [D_W-1:0] expected_c;

    // Reference ALU used only to flag results that disagree with the external unit.
    always_comb begin
        expected_c = '0;
        case (alu_op_q)
            OP_W'(0): expected_c = alu_a_q + alu_b_q;
            OP_W'(1): expected_c = alu_a_q - alu_b_q;
            OP_W'(2): expected_c = alu_a_q & alu_b_q;
            OP_W'(3): expected_c = alu_a_q | alu_b_q;
            OP_W'(4): expected_c = alu_a_q ^ alu_b_q;
            OP_W'(5): expected_c = ~alu_a_q;
            default:  expected_c = '0;
        endcase
    end

    assign mismatch_c = (alu_result != expected_c);
`else
    assign mismatch_c = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        mem_d          = mem_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_op_d       = rsp_op_q;
        rsp_illegal_d  = rsp_illegal_q;
        rsp_mismatch_d = rsp_mismatch_q;

        if (push_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{op: cmd_op, b: cmd_b, a: cmd_a};
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    alu_a_d  = head_c.a;
                    alu_b_d  = head_c.b;
                    alu_op_d = head_c.op;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = EXEC;
                end
            end
            // ALU inputs have been stable for a full cycle; capture its result.
            EXEC: begin
                rsp_result_d   = alu_result;
                rsp_op_d       = alu_op_q;
                rsp_illegal_d  = (alu_op_q >= OP_ILLEGAL_MIN);
                rsp_mismatch_d = mismatch_c;
                rsp_valid_d    = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_op_q       <= '0;
            rsp_illegal_q  <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_op_q       <= rsp_op_d;
            rsp_illegal_q  <= rsp_illegal_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            busy_q         <= busy_d;
        end
    end

    // Entry storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_op       = rsp_op_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural external ALU and a result-override hook.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_illegal, rsp_mismatch, busy;
    logic       force_zero;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ALU_ISSUE_CHECK_EN
    localparam logic MM_ON_FORCED = 1'b1;
`else
    localparam logic MM_ON_FORCED = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op),
        .rsp_illegal(rsp_illegal), .rsp_mismatch(rsp_mismatch),
        .busy(busy)
    );

    // External combinational ALU seen by the DUT.
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~a;
            default: return 4'h0;
        endcase
    endfunction

    always_comb alu_result = force_zero ? 4'h0 : alu_f(alu_a, alu_b, alu_opcode);

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        while (!cmd_ready && n < 50) begin
            tick;
            n++;
        end
        check("send_accept", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [3:0] er, input logic [2:0] eo,
                            input logic ei, input logic em);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, 32'(rsp_result), 32'(er));
        check({tag, "_op"}, 32'(rsp_op), 32'(eo));
        check({tag, "_illegal"}, 32'(rsp_illegal), 32'(ei));
        check({tag, "_mismatch"}, 32'(rsp_mismatch), 32'(em));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int accepted;
        int idx;
        int stale;
        logic will;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;
        force_zero = 1'b0;
        tick;
        tick;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick;

        // Add with wrap and latency: 9 + 8 = 1
        send(4'd9, 4'd8, 3'b000);
        check("add_lat_e1_valid", 32'(rsp_valid), 32'd0);
        tick;
        check("add_lat_e2_valid", 32'(rsp_valid), 32'd0);
        check("add_alu_drive", 32'({alu_a, alu_b, alu_opcode}), 32'({4'd9, 4'd8, 3'b000}));
        check("add_busy", 32'(busy), 32'd1);
        tick;
        check("add_lat_valid", 32'(rsp_valid), 32'd1);
        wait_rsp("add", 4'd1, 3'b000, 1'b0, 1'b0);

        // Sub with borrow then NOT, in issue order
        send(4'd3, 4'd5, 3'b001);
        send(4'd5, 4'd0, 3'b101);
        wait_rsp("sub", 4'd14, 3'b001, 1'b0, 1'b0);
        wait_rsp("not", 4'd10, 3'b101, 1'b0, 1'b0);

        // Illegal opcode
        send(4'd7, 4'd7, 3'b110);
        wait_rsp("ill", 4'd0, 3'b110, 1'b1, 1'b0);
        tick;

        // Backpressure: stream 6, expect 5 accepted and first response held
        accepted = 0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = (idx < 6);
            cmd_a = 4'(idx + 1);
            cmd_b = 4'd1;
            cmd_op = 3'b000;
            will = cmd_valid && cmd_ready;
            tick;
            if (will) begin
                accepted++;
                idx++;
            end
            if (rsp_valid)
                check("bp_hold", 32'({rsp_valid, rsp_op, rsp_result}), 32'({1'b1, 3'b000, 4'd2}));
        end
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b0;
        wait_rsp("bp0", 4'd2, 3'b000, 1'b0, 1'b0);
        wait_rsp("bp1", 4'd3, 3'b000, 1'b0, 1'b0);
        wait_rsp("bp2", 4'd4, 3'b000, 1'b0, 1'b0);
        wait_rsp("bp3", 4'd5, 3'b000, 1'b0, 1'b0);
        wait_rsp("bp4", 4'd6, 3'b000, 1'b0, 1'b0);
        check("bp_end_cmd_ready", 32'(cmd_ready), 32'd1);
        check("bp_end_busy", 32'(busy), 32'd0);

        // Reset while a response is held with three commands queued
        send(4'd1, 4'd1, 3'b000);
        send(4'd2, 4'd1, 3'b000);
        send(4'd3, 4'd1, 3'b000);
        send(4'd4, 4'd1, 3'b000);
        idx = 0;
        while (!rsp_valid && idx < 20) begin
            tick;
            idx++;
        end
        check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (rsp_valid || busy) stale++;
        end
        rsp_ready = 1'b0;
        check("mid_no_stale", 32'(stale), 32'd0);

        // Forced wrong ALU result: 1 + 1 returned as 0
        force_zero = 1'b1;
        send(4'd1, 4'd1, 3'b000);
        wait_rsp("force", 4'd0, 3'b000, 1'b0, MM_ON_FORCED);
        force_zero = 1'b0;

        // Legal op with correct ALU never flags mismatch
        send(4'd12, 4'd10, 3'b100);
        wait_rsp("xor", 4'd6, 3'b100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
